layer_stream_sequencer: RTL and testbench

- Sequences the parallel result of one neuron layer into the serial input stream of the next layer.
- Captures all NN neuron outputs when the layer reports valid, then emits them one per clock on a data/valid stream. This stream is the x_in/x_valid pair the next layer consumes.
- Sits between consecutive layers in the network top, one instance per layer boundary.
- Tracks error conditions with sticky flags: capture attempted while busy, and neuron valid bits out of sync.

---
 rtl/layer_stream_sequencer.sv | 105 ++++++++++
 tb/tb_layer_stream_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_stream_sequencer.sv
// Captures one layer's parallel neuron outputs and replays them as a serial
// data/valid stream for the next layer, with sticky overrun/mismatch flags.
//
// state | meaning
// IDLE  | no burst in flight, out_valid low, waiting for in_valid[0]
// SEND  | emitting element idx of the captured burst, out_valid high
module layer_stream_sequencer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    input  logic                    clr_err,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic                    mismatch
);

    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_n;
    logic [IW-1:0]           idx_q, idx_n, idx_inc;
    logic [NN*dataWidth-1:0] buffer_q, buffer_n;
    logic [dataWidth-1:0]    data_q, data_n;
    logic                    done_q, done_n;
    logic                    overrun_q, overrun_n;
    logic                    mismatch_q, mismatch_n;
    logic                    last, acc, ovr_set, mm_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            buffer_q   <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            buffer_q   <= buffer_n;
            data_q     <= data_n;
            done_q     <= done_n;
            overrun_q  <= overrun_n;
            mismatch_q <= mismatch_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        buffer_n = buffer_q;
        data_n   = data_q;
        done_n   = 1'b0;
        idx_inc  = idx_q + 1'b1;

        last    = (state_q == SEND) && (idx_q == IW'(NN - 1));
        acc     = in_valid[0] && ((state_q == IDLE) || last);
        ovr_set = in_valid[0] && (state_q == SEND) && !last;
        mm_set  = acc && (in_valid != '1);

        if (acc) begin
            // Element 0 bypasses the buffer so a burst can follow the previous one with no gap.
            state_n  = SEND;
            idx_n    = '0;
            buffer_n = in_data;
            data_n   = in_data[dataWidth-1:0];
            done_n   = (NN == 1);
        end else if ((state_q == SEND) && !last) begin
            idx_n  = idx_inc;
            data_n = buffer_q[int'(idx_inc)*dataWidth +: dataWidth];
            done_n = (idx_inc == IW'(NN - 1));
        end else if (last) begin
            state_n = IDLE;
        end

        // A flag being set on the same edge as clr_err wins over the clear.
        if (ovr_set)      overrun_n = 1'b1;
        else if (clr_err) overrun_n = 1'b0;
        else              overrun_n = overrun_q;

        if (mm_set)       mismatch_n = 1'b1;
        else if (clr_err) mismatch_n = 1'b0;
        else              mismatch_n = mismatch_q;
    end

    assign out_valid = (state_q == SEND);
    assign busy      = out_valid;
    assign out_data  = data_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Directed bench for layer_stream_sequencer: an NN=4 instance for bursts,
// overrun, mismatch and reset, plus an NN=1 instance for the degenerate case.
module tb_layer_stream_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid4;
    logic [4*DW-1:0] in_data4;
    logic          clr_err4;
    logic          out_valid4, busy4, done4, overrun4, mismatch4;
    logic [DW-1:0] out_data4;

    logic [0:0]    in_valid1;
    logic [DW-1:0] in_data1;
    logic          clr_err1;
    logic          out_valid1, busy1, done1, overrun1, mismatch1;
    logic [DW-1:0] out_data1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    layer_stream_sequencer #(.NN(4), .dataWidth(DW)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
        .clr_err(clr_err4), .out_valid(out_valid4), .out_data(out_data4),
        .busy(busy4), .done(done4), .overrun(overrun4), .mismatch(mismatch4)
    );

    layer_stream_sequencer #(.NN(1), .dataWidth(DW)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .clr_err(clr_err1), .out_valid(out_valid1), .out_data(out_data1),
        .busy(busy1), .done(done1), .overrun(overrun1), .mismatch(mismatch1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_elem(input string tag, input logic [15:0] data, input logic dn);
        check_val({tag, "_data"}, 32'(out_data4), 32'(data));
        check_val({tag, "_valid"}, 32'(out_valid4), 32'd1);
        check_val({tag, "_busy"}, 32'(busy4), 32'(out_valid4));
        check_val({tag, "_done"}, 32'(done4), 32'(dn));
    endtask

    logic [4*DW-1:0] burst_a = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    logic [4*DW-1:0] burst_b = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    logic [4*DW-1:0] burst_x = {16'h9999, 16'h8888, 16'h7777, 16'h6666};
    logic [15:0]     exp_a [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    logic [15:0]     exp_ab [8] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044,
                                    16'h000A, 16'h000B, 16'h000C, 16'h000D};
    logic [15:0]     exp_one [3] = '{16'h0005, 16'h0006, 16'h0007};

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid4 = '0; in_data4 = '0; clr_err4 = 1'b0;
        in_valid1 = '0; in_data1 = '0; clr_err1 = 1'b0;
        tick();
        tick();
        check_val("rst_valid", 32'(out_valid4), 32'd0);
        check_val("rst_data", 32'(out_data4), 32'd0);
        check_val("rst_done", 32'(done4), 32'd0);
        check_val("rst_busy", 32'(busy4), 32'd0);
        check_val("rst_flags", {30'd0, overrun4, mismatch4}, 32'd0);
        rst = 1'b0;
        tick();

        // basic burst
        in_data4 = burst_a; in_valid4 = 4'hF;
        tick();
        in_valid4 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check_elem("basic", exp_a[i], i == 3);
            tick();
        end
        check_val("basic_end_valid", 32'(out_valid4), 32'd0);
        check_val("basic_end_hold", 32'(out_data4), 32'h0044);
        check_val("basic_end_done", 32'(done4), 32'd0);
        check_val("basic_flags", {30'd0, overrun4, mismatch4}, 32'd0);
        tick();

        // back-to-back with second trigger in the done cycle
        in_data4 = burst_a; in_valid4 = 4'hF;
        tick();
        in_valid4 = 4'h0;
        for (int c = 0; c < 8; c++) begin
            check_elem("b2b", exp_ab[c], (c == 3) || (c == 7));
            if (c == 3) begin
                in_data4 = burst_b; in_valid4 = 4'hF;
            end else begin
                in_valid4 = 4'h0;
            end
            tick();
        end
        in_valid4 = 4'h0;
        check_val("b2b_end_valid", 32'(out_valid4), 32'd0);
        check_val("b2b_flags", {30'd0, overrun4, mismatch4}, 32'd0);
        tick();

        // overrun at idx 1
        in_data4 = burst_a; in_valid4 = 4'hF;
        tick();
        in_valid4 = 4'h0;
        check_elem("ovr0", 16'h0011, 1'b0);
        tick();
        check_elem("ovr1", 16'h0022, 1'b0);
        in_data4 = burst_x; in_valid4 = 4'hF;
        tick();
        in_valid4 = 4'h0;
        check_elem("ovr2", 16'h0033, 1'b0);
        check_val("ovr_set", 32'(overrun4), 32'd1);
        tick();
        check_elem("ovr3", 16'h0044, 1'b1);
        check_val("ovr_sticky", 32'(overrun4), 32'd1);
        tick();
        check_val("ovr_end_valid", 32'(out_valid4), 32'd0);
        check_val("ovr_end_data", 32'(out_data4), 32'h0044);
        tick();
        check_val("ovr_no_new", 32'(out_valid4), 32'd0);
        clr_err4 = 1'b1;
        tick();
        clr_err4 = 1'b0;
        check_val("ovr_clr", 32'(overrun4), 32'd0);

        // mismatch with simultaneous clear
        in_data4 = burst_a; in_valid4 = 4'b0111; clr_err4 = 1'b1;
        tick();
        in_valid4 = 4'h0; clr_err4 = 1'b0;
        check_val("mm_set", 32'(mismatch4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_elem("mm", exp_a[i], i == 3);
            tick();
        end
        check_val("mm_sticky", 32'(mismatch4), 32'd1);
        check_val("mm_no_ovr", 32'(overrun4), 32'd0);
        clr_err4 = 1'b1;
        tick();
        clr_err4 = 1'b0;
        check_val("mm_clr", 32'(mismatch4), 32'd0);

        // reset mid-burst (mismatch set first so the reset has a flag to clear)
        in_data4 = burst_a; in_valid4 = 4'b0111;
        tick();
        in_valid4 = 4'h0;
        tick();
        check_elem("rmb1", 16'h0022, 1'b0);
        check_val("rmb_mm_pre", 32'(mismatch4), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rmb_valid", 32'(out_valid4), 32'd0);
        check_val("rmb_data", 32'(out_data4), 32'd0);
        check_val("rmb_done", 32'(done4), 32'd0);
        check_val("rmb_flags", {30'd0, overrun4, mismatch4}, 32'd0);
        tick();
        check_val("rmb_no_resume", 32'(out_valid4), 32'd0);
        in_data4 = burst_b; in_valid4 = 4'hF;
        tick();
        in_valid4 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check_elem("rmb_new", exp_ab[4+i], i == 3);
            tick();
        end
        check_val("rmb_new_end", 32'(out_valid4), 32'd0);

        // NN=1: consecutive single-element bursts
        for (int i = 0; i < 3; i++) begin
            in_valid1 = 1'b1; in_data1 = 16'(5 + i);
            tick();
            check_val("nn1_data", 32'(out_data1), 32'(exp_one[i]));
            check_val("nn1_valid", 32'(out_valid1), 32'd1);
            check_val("nn1_done", 32'(done1), 32'd1);
            check_val("nn1_ovr", 32'(overrun1), 32'd0);
        end
        in_valid1 = 1'b0;
        tick();
        check_val("nn1_end_valid", 32'(out_valid1), 32'd0);
        check_val("nn1_end_done", 32'(done1), 32'd0);
        check_val("nn1_end_data", 32'(out_data1), 32'h0007);
        check_val("nn1_mm", 32'(mismatch1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
